// File: rtl/ifu_pkg.sv
// ifu_pkg: shared states, opcodes and field positions for the instruction fetch stage
package ifu_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
  localparam logic [1:0] OP_CTRL  = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;
  localparam int OP_MSB   = 19;
  localparam int JMP_LSB  = 4;
  localparam int JMP_FLAG = 0;
endpackage

// File: rtl/ifu_prog_mem.sv
// ifu_prog_mem: program RAM, synchronous read, write-first when read and write hit the same word
module ifu_prog_mem #(
  parameter int W = 20,
  parameter int A = 5
) (
  input  logic         clk,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [A-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [2**A];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/simple_instr_fetch.sv
// simple_instr_fetch: program memory + PC walker feeding simple_cpu over valid/ready.
// Define IFU_JUMP_EN to treat opcode 00 words with bit 0 set as JUMP instead of HALT.
module simple_instr_fetch
  import ifu_pkg::*;
#(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_wdata,
  input  logic                   start,
  input  logic                   cpu_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   halted
);
  state_t state;
  logic [INSTR_WIDTH-1:0] rdata;
  logic [PC_BITS-1:0] pc_nxt;
  logic idle_like, is_jump;
  assign idle_like = state == IDLE || state == HALT;
`ifdef IFU_JUMP_EN
  assign is_jump = rdata[INSTR_WIDTH-1 -: 2] == OP_CTRL && rdata[JMP_FLAG];
`else
  assign is_jump = 1'b0;
`endif
  // The RAM is addressed with next-cycle PC so the word is already read out while in FETCH.
  assign pc_nxt = !rst                     ? '0 :
                  (idle_like && start)     ? '0 :
                  (state == FETCH && is_jump) ? rdata[JMP_LSB +: PC_BITS] :
                  (state == ISSUE && cpu_ready) ? pc + 1'b1 : pc;
  ifu_prog_mem #(.W(INSTR_WIDTH), .A(PC_BITS)) u_mem (
    .clk  (clk),
    .we   (prog_we && idle_like),
    .waddr(prog_addr),
    .wdata(prog_wdata),
    .raddr(pc_nxt),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      pc <= pc_nxt;
      case (state)
        IDLE: if (start) state <= FETCH;
        FETCH:
          if (rdata[INSTR_WIDTH-1 -: 2] != OP_CTRL) begin
            state       <= ISSUE;
            instruction <= rdata;
            instr_valid <= 1'b1;
          end else if (!is_jump) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        ISSUE:
          if (cpu_ready) begin
            state       <= FETCH;
            instruction <= '0;
            instr_valid <= 1'b0;
          end
        HALT:
          if (start) begin
            state  <= FETCH;
            halted <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simple_instr_fetch.sv
// tb_simple_instr_fetch: randomized bench against a program-walking reference model
module tb_simple_instr_fetch;
  localparam int IW = 20, PB = 5, DEPTH = 32;
  logic clk = 0, rst = 0, prog_we = 0, start = 0, cpu_ready = 0;
  logic [PB-1:0] prog_addr = '0;
  logic [IW-1:0] prog_wdata = '0;
  logic [IW-1:0] instruction;
  logic instr_valid, halted;
  logic [PB-1:0] pc;
  int checks = 0, errors = 0;
  logic [IW-1:0] model [DEPTH];
  logic exp_h;
  logic [IW-1:0] exp_w;
  logic [PB-1:0] exp_at;
  int hops, since;

  always #5 clk = ~clk;

  simple_instr_fetch dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .start(start), .cpu_ready(cpu_ready), .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Next word the CPU should see when walking from 'from': skips jumps, stops at a halt.
  task automatic walk(input logic [PB-1:0] from, output logic h, output logic [IW-1:0] w,
                      output logic [PB-1:0] at, output int n);
    at = from; n = 0; h = 0; w = '0;
    repeat (DEPTH + 1) begin
      if (model[at][19:18] != 2'b00) begin
        w = model[at];
        return;
      end
`ifdef IFU_JUMP_EN
      if (model[at][0]) begin
        at = model[at][8:4];
        n++;
        continue;
      end
`endif
      h = 1;
      return;
    end
  endtask

  task automatic load(input int a, input logic [IW-1:0] d);
    prog_we = 1; prog_addr = 5'(a); prog_wdata = d;
    tick;
    prog_we = 0;
    model[a] = d;
  endtask

  task automatic do_reset;
    rst = 0; cpu_ready = 1;
    tick;
    rst = 1; cpu_ready = 0;
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
  endtask

  task automatic launch(input logic we, input logic [PB-1:0] a, input logic [IW-1:0] d);
    prog_we = we; prog_addr = a; prog_wdata = d; start = 1;
    tick;
    prog_we = 0; start = 0;
    if (we) model[a] = d;
    walk('0, exp_h, exp_w, exp_at, hops);
    since = 0;
    chk("launch_valid", instr_valid, 0);
    chk("launch_halted", halted, 0);
  endtask

  task automatic run(input int pct, input int max_x);
    int x;
    logic v, r, done;
    logic [IW-1:0] w;
    x = 0; done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      r = $urandom_range(99) < pct;
      cpu_ready = r;
      start = $urandom_range(3) == 0;
      prog_we = $urandom_range(3) == 0;
      prog_addr = 5'($urandom);
      prog_wdata = 20'($urandom);
      v = instr_valid; w = instruction;
      tick;
      if (v && r) begin
        chk("xfer_word", w, exp_w);
        chk("xfer_drop", instr_valid, 0);
        x++;
        walk(exp_at + 1'b1, exp_h, exp_w, exp_at, hops);
        since = 0;
        if (x == max_x) done = 1;
      end else if (v) begin
        chk("hold_word", instruction, w);
        chk("hold_valid", instr_valid, 1);
        chk("hold_pc", pc, exp_at);
      end else begin
        since++;
        if (since == hops + 1) begin
          chk("appear_valid", instr_valid, !exp_h);
          chk("appear_halted", halted, exp_h);
          chk("appear_pc", pc, exp_at);
          if (!exp_h) chk("appear_word", instruction, exp_w);
          if (exp_h) done = 1;
        end else begin
          chk("fetch_valid", instr_valid, 0);
          chk("fetch_word", instruction, 0);
        end
      end
    end
    cpu_ready = 0; start = 0; prog_we = 0;
    chk("run_budget", done, 1);
  endtask

  initial begin
    logic [IW-1:0] wd;
    tick; tick;
    chk("por_valid", instr_valid, 0);
    chk("por_instr", instruction, 0);
    chk("por_pc", pc, 0);
    chk("por_halted", halted, 0);
    rst = 1;
    for (int i = 0; i < DEPTH; i++) load(i, '0);
    load(0, 20'b01000111000000000000);
    load(1, 20'b01110010000000000001);
    load(2, '0);
    launch(0, '0, '0);
    run(100, 10);
    chk("plan_halted", halted, 1);
    chk("plan_pc", pc, 2);
    launch(0, '0, '0);
    tick;
    chk("stall_first", instruction, 20'h47000);
    repeat (5) begin
      tick;
      chk("stall_word", instruction, 20'h47000);
      chk("stall_valid", instr_valid, 1);
      chk("stall_pc", pc, 0);
    end
    cpu_ready = 1;
    tick;
    cpu_ready = 0;
    chk("stall_xfer_pc", pc, 1);
    tick;
    chk("second_word", instruction, 20'h72001);
    rst = 0; cpu_ready = 1;
    tick;
    rst = 1; cpu_ready = 0;
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_instr", instruction, 0);
    launch(0, '0, '0);
    run(100, 10);
    launch(0, '0, '0);
    tick;
    prog_we = 1; prog_addr = '0; prog_wdata = 20'hFFFFF;
    tick;
    prog_we = 0;
    chk("issue_we_held", instruction, 20'h47000);
    run(70, 10);
    launch(1, '0, 20'hFFFFF);
    run(100, 10);
    load(0, 20'h47000);
    load(2, 20'h47000);
    load(3, 20'h00001);
    launch(0, '0, '0);
    run(100, 9);
    chk("jump_halted", halted, exp_h);
    do_reset;
    for (int i = 0; i < DEPTH; i++) load(i, 20'h47000);
    launch(0, '0, '0);
    run(100, 40);
    for (int k = 0; k < 6; k++) begin
      do_reset;
      for (int i = 0; i < DEPTH; i++) begin
        wd = 20'($urandom);
        if ($urandom_range(5) == 0) begin
          wd[19:18] = 2'b00;
          wd[0] = 0;
          if (i < DEPTH - 1 && $urandom_range(1) == 1) begin
            wd[8:4] = 5'($urandom_range(DEPTH - 1, i + 1));
            wd[0] = 1;
          end
        end else wd[19:18] = 2'($urandom_range(3, 1));
        load(i, wd);
      end
      launch(0, '0, '0);
      run(30 + $urandom_range(70), 200);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
